// File: rtl/cpu_types_pkg.sv
// Purpose: ISA-level encodings shared by the decoders (MIPS opcode and
//          funct fields) and the ALU operation select.
// Contents: opcode_t, funct_t, aluop_t.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_LL    = 6'h30,
        OP_SC    = 6'h38,
        OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/datapath_types_pkg.sv
// Purpose: multicycle datapath control encodings: sequencer state,
//          ALU B-operand select, PC source select and the instruction
//          class produced by the decoder.
// Contents: mcstate_t, alusrcb_t, pcsrc_t, instr_class_t.
package datapath_types_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_EXEC_MEM = 4'd4,
        S_MEM      = 4'd5,
        S_WB       = 4'd6,
        S_BRANCH   = 4'd7,
        S_JUMP     = 4'd8,
        S_JUMPR    = 4'd9,
        S_HALT     = 4'd10
    } mcstate_t;

    typedef enum logic [1:0] {
        SRCB_REG      = 2'd0,
        SRCB_FOUR     = 2'd1,
        SRCB_IMM      = 2'd2,
        SRCB_IMM_SHL2 = 2'd3
    } alusrcb_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pcsrc_t;

    typedef enum logic [3:0] {
        CL_RTYPE   = 4'd0,
        CL_JR      = 4'd1,
        CL_IALU    = 4'd2,
        CL_LW      = 4'd3,
        CL_SW      = 4'd4,
        CL_LL      = 4'd5,
        CL_SC      = 4'd6,
        CL_BEQ     = 4'd7,
        CL_BNE     = 4'd8,
        CL_J       = 4'd9,
        CL_JAL     = 4'd10,
        CL_HALT    = 4'd11,
        CL_ILLEGAL = 4'd12
    } instr_class_t;

endpackage

// File: rtl/mc_instr_decode.sv
// Purpose: combinational instruction classifier for the multicycle control
//          unit. Maps opcode/funct to an instruction class, the ALU op used
//          in the execute step and the immediate extension mode.
// Ports:   i_opcode, i_funct  - IR fields
//          o_class            - instr_class_t (CL_ILLEGAL if undecodable)
//          o_aluop            - ALU operation for EXEC_R / EXEC_I
//          o_extop            - 1 = sign-extend the 16-bit immediate
module mc_instr_decode
    import cpu_types_pkg::*;
    import datapath_types_pkg::*;
#(
    parameter int LLSC_EN = 1
) (
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output instr_class_t o_class,
    output aluop_t       o_aluop,
    output logic         o_extop
);

    always_comb begin
        o_class = CL_ILLEGAL;
        o_aluop = ALU_ADD;
        o_extop = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_class = CL_RTYPE;
                case (i_funct)
                    FN_SLL:          o_aluop = ALU_SLL;
                    FN_SRL:          o_aluop = ALU_SRL;
                    FN_ADD, FN_ADDU: o_aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: o_aluop = ALU_SUB;
                    FN_AND:          o_aluop = ALU_AND;
                    FN_OR:           o_aluop = ALU_OR;
                    FN_XOR:          o_aluop = ALU_XOR;
                    FN_NOR:          o_aluop = ALU_NOR;
                    FN_SLT:          o_aluop = ALU_SLT;
                    FN_SLTU:         o_aluop = ALU_SLTU;
                    FN_JR:           o_class = CL_JR;
                    default:         o_class = CL_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                o_class = CL_IALU;
                o_aluop = ALU_ADD;
                o_extop = 1'b1;
            end
            OP_SLTI: begin
                o_class = CL_IALU;
                o_aluop = ALU_SLT;
                o_extop = 1'b1;
            end
            OP_SLTIU: begin
                o_class = CL_IALU;
                o_aluop = ALU_SLTU;
                o_extop = 1'b1;
            end
            OP_ANDI: begin
                o_class = CL_IALU;
                o_aluop = ALU_AND;
            end
            // LUI: rs is $0, so OR passes the shifted immediate through
            OP_ORI, OP_LUI: begin
                o_class = CL_IALU;
                o_aluop = ALU_OR;
            end
            OP_XORI: begin
                o_class = CL_IALU;
                o_aluop = ALU_XOR;
            end
            OP_LW: begin
                o_class = CL_LW;
                o_extop = 1'b1;
            end
            OP_SW: begin
                o_class = CL_SW;
                o_extop = 1'b1;
            end
            OP_LL: begin
                if (LLSC_EN != 0) begin
                    o_class = CL_LL;
                    o_extop = 1'b1;
                end
            end
            OP_SC: begin
                if (LLSC_EN != 0) begin
                    o_class = CL_SC;
                    o_extop = 1'b1;
                end
            end
            OP_BEQ: begin
                o_class = CL_BEQ;
                o_aluop = ALU_SUB;
                o_extop = 1'b1;
            end
            OP_BNE: begin
                o_class = CL_BNE;
                o_aluop = ALU_SUB;
                o_extop = 1'b1;
            end
            OP_J:    o_class = CL_J;
            OP_JAL:  o_class = CL_JAL;
            OP_HALT: o_class = CL_HALT;
            default: o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: multicycle MIPS control FSM. Sequences each instruction through
//          FETCH/DECODE/EXEC/MEM/WB, stalls on ihit/dhit, optional LL/SC and
//          an optional wait-timeout that halts the core.
// Ports:   CLK, nRST (sync, active-low); opcode/funct from IR; ihit/dhit
//          cache handshakes; zero from the ALU (used in BRANCH);
//          iREN/dREN/dWEN memory requests; PCWr/IRWr/RegWr write enables;
//          RegDst/WrLinkReg/MemToReg/ExtOp/ShiftUp/ALUSrcA/ALUSrcB/ALUOp/
//          PCSrc datapath selects; halt (sticky), illegal (pulse),
//          timeout (sticky), state_o (debug).
module multicycle_control_unit
    import cpu_types_pkg::*;
    import datapath_types_pkg::*;
#(
    parameter int LLSC_EN     = 1,
    parameter int TIMEOUT_CYC = 0,
    parameter int TMO_W       = 8
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       zero,
    output logic       iREN,
    output logic       dREN,
    output logic       dWEN,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       WrLinkReg,
    output logic       MemToReg,
    output logic       ExtOp,
    output logic       ShiftUp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       halt,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state_o
);

    localparam bit               TMO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    mcstate_t         r_state;
    mcstate_t         w_next;
    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_timeout;
    instr_class_t     w_class;
    aluop_t           w_dec_aluop;
    logic             w_dec_extop;
    logic             w_waiting;
    logic             w_tmo_fire;
    logic             w_is_load;
    logic             w_is_store;

    mc_instr_decode #(.LLSC_EN(LLSC_EN)) u_dec (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class),
        .o_aluop  (w_dec_aluop),
        .o_extop  (w_dec_extop)
    );

    assign w_is_load  = (w_class == CL_LW) || (w_class == CL_LL);
    assign w_is_store = (w_class == CL_SW) || (w_class == CL_SC);

    // A hit on the limit cycle makes w_waiting low, so the hit wins.
    assign w_waiting  = ((r_state == S_FETCH) && !ihit) ||
                        ((r_state == S_MEM)   && !dhit);
    assign w_tmo_fire = TMO_EN && w_waiting && (r_wait_cnt == TMO_LIM);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any non-waiting cycle (hit or state change) restarts the count
            if (TMO_EN && w_waiting && !w_tmo_fire)
                r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_tmo_fire)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (ihit)            w_next = S_DECODE;
                else if (w_tmo_fire) w_next = S_HALT;
            end
            S_DECODE: begin
                case (w_class)
                    CL_HALT:                    w_next = S_HALT;
                    CL_J, CL_JAL:               w_next = S_JUMP;
                    CL_BEQ, CL_BNE:             w_next = S_BRANCH;
                    CL_LW, CL_SW, CL_LL, CL_SC: w_next = S_EXEC_MEM;
                    CL_RTYPE:                   w_next = S_EXEC_R;
                    CL_JR:                      w_next = S_JUMPR;
                    CL_IALU:                    w_next = S_EXEC_I;
                    default:                    w_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB;
            S_EXEC_MEM:         w_next = S_MEM;
            S_MEM: begin
                if (dhit)            w_next = (w_class == CL_SW) ? S_FETCH : S_WB;
                else if (w_tmo_fire) w_next = S_HALT;
            end
            S_WB, S_BRANCH, S_JUMP, S_JUMPR: w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // While nRST is low every output shows its reset value, so a reset
    // landing mid-instruction cannot let a pending write through.
    always_comb begin
        iREN      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        RegWr     = 1'b0;
        RegDst    = 1'b0;
        WrLinkReg = 1'b0;
        MemToReg  = 1'b0;
        ExtOp     = 1'b0;
        ShiftUp   = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALU_ADD;
        PCSrc     = PC_ALU;
        halt      = 1'b0;
        illegal   = 1'b0;
        timeout   = r_timeout && nRST;
        if (!nRST) begin
            iREN = 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    iREN = 1'b1;
                    IRWr = ihit;
                    PCWr = ihit;
                end
                S_DECODE: begin
                    // Branch target PC + (sext(imm) << 2) into ALUOut
                    ALUSrcB = SRCB_IMM_SHL2;
                    ExtOp   = 1'b1;
                    illegal = (w_class == CL_ILLEGAL);
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    ALUOp   = w_dec_aluop;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = w_dec_aluop;
                    ExtOp   = w_dec_extop;
                    ShiftUp = (opcode == OP_LUI);
                end
                S_EXEC_MEM: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ExtOp   = 1'b1;
                end
                S_MEM: begin
                    dREN = w_is_load;
                    dWEN = w_is_store;
                end
                S_WB: begin
                    RegWr     = 1'b1;
                    MemToReg  = w_is_load;
                    WrLinkReg = (w_class == CL_LL);
                    RegDst    = (w_class == CL_RTYPE);
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    ALUOp   = ALU_SUB;
                    PCSrc   = PC_ALUOUT;
                    PCWr    = zero ^ (w_class == CL_BNE);
                end
                S_JUMP: begin
                    PCWr  = 1'b1;
                    PCSrc = PC_JUMP;
                    if (w_class == CL_JAL) begin
                        RegWr     = 1'b1;
                        WrLinkReg = 1'b1;
                    end
                end
                S_JUMPR: begin
                    ALUSrcA = 1'b1;
                    PCWr    = 1'b1;
                    PCSrc   = PC_JR;
                end
                S_HALT:  halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
    import cpu_types_pkg::*;
    import datapath_types_pkg::*;

    localparam int TMO = 4;

    localparam logic [11:0] C_IREN  = 12'h800;
    localparam logic [11:0] C_IRWR  = 12'h400;
    localparam logic [11:0] C_PCWR  = 12'h200;
    localparam logic [11:0] C_REGWR = 12'h100;
    localparam logic [11:0] C_DREN  = 12'h080;
    localparam logic [11:0] C_DWEN  = 12'h040;
    localparam logic [11:0] C_RDST  = 12'h020;
    localparam logic [11:0] C_M2R   = 12'h010;
    localparam logic [11:0] C_LINK  = 12'h008;
    localparam logic [11:0] C_ILL   = 12'h004;
    localparam logic [11:0] C_HALT  = 12'h002;
    localparam logic [11:0] C_TMO   = 12'h001;

    localparam int K_R = 0, K_JR = 1, K_I = 2, K_LW = 3, K_SW = 4, K_LL = 5, K_SC = 6;
    localparam int K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10, K_HALT = 11, K_ILL = 12;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
    logic       iREN, dREN, dWEN, PCWr, IRWr, RegWr, RegDst, WrLinkReg, MemToReg;
    logic       ExtOp, ShiftUp, ALUSrcA, halt, illegal, timeout;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUOp, state_o;
    logic [11:0] ctl;

    always #5 CLK = ~CLK;

    multicycle_control_unit #(.LLSC_EN(1), .TIMEOUT_CYC(TMO), .TMO_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .opcode(opcode), .funct(funct),
        .ihit(ihit), .dhit(dhit), .zero(zero),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .PCWr(PCWr), .IRWr(IRWr),
        .RegWr(RegWr), .RegDst(RegDst), .WrLinkReg(WrLinkReg), .MemToReg(MemToReg),
        .ExtOp(ExtOp), .ShiftUp(ShiftUp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .halt(halt), .illegal(illegal),
        .timeout(timeout), .state_o(state_o)
    );

    assign ctl = {iREN, IRWr, PCWr, RegWr, dREN, dWEN, RegDst, MemToReg,
                  WrLinkReg, illegal, halt, timeout};

    // Instruction table: encoding, class and expected execute ALU op
    logic [5:0] t_op [24] = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE,
                              OP_RTYPE, OP_RTYPE, OP_ADDIU, OP_ORI, OP_SLTIU, OP_LUI,
                              OP_LW, OP_SW, OP_LL, OP_SC, OP_BEQ, OP_BNE, OP_J, OP_JAL,
                              OP_HALT, 6'h11, OP_RTYPE, OP_XORI};
    logic [5:0] t_fn [24] = '{FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL,
                              FN_JR, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h00};
    int         t_kind [24] = '{K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_JR, K_I, K_I, K_I, K_I,
                                K_LW, K_SW, K_LL, K_SC, K_BEQ, K_BNE, K_J, K_JAL, K_HALT,
                                K_ILL, K_ILL, K_I};
    logic [3:0] t_alu [24] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL,
                               ALU_ADD, ALU_ADD, ALU_OR, ALU_SLTU, ALU_OR, ALU_ADD, ALU_ADD,
                               ALU_ADD, ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_ADD,
                               ALU_ADD, ALU_ADD, ALU_XOR};

    typedef struct {
        logic        ih, dh, z;
        logic [3:0]  st;
        logic [11:0] c;
        logic        ca;
        logic [3:0]  alu;
        logic [1:0]  pcs;
    } rec_t;

    rec_t q[$];
    bit   m_tmo;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void push(input logic ih, input logic dh, input logic z,
                                 input mcstate_t st, input logic [11:0] c,
                                 input logic ca, input logic [3:0] alu, input pcsrc_t pcs);
        rec_t r;
        r.ih = ih; r.dh = dh; r.z = z; r.st = st; r.c = c;
        r.ca = ca; r.alu = alu; r.pcs = pcs;
        q.push_back(r);
    endfunction

    function automatic void push_halt();
        for (int i = 0; i < 3; i++)
            push(0, 0, 0, S_HALT, C_HALT | (m_tmo ? C_TMO : 12'h0), 0, 0, PC_ALU);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction: fw cycles of
    // missing ihit, dw cycles of missing dhit, zero flag for branches.
    task automatic build(input int idx, input int fw, input int dw, input logic z,
                         output bit stop);
        int          k = t_kind[idx];
        logic [11:0] md;
        stop = 0;
        for (int w = 0; w < fw; w++) begin
            push(0, 0, 0, S_FETCH, C_IREN, 0, 0, PC_ALU);
            if (w == TMO) begin
                m_tmo = 1; push_halt(); stop = 1; return;
            end
        end
        push(1, 0, 0, S_FETCH, C_IREN | C_IRWR | C_PCWR, 0, 0, PC_ALU);
        push(0, 0, 0, S_DECODE, (k == K_ILL) ? C_ILL : 12'h0, 1, ALU_ADD, PC_ALU);
        case (k)
            K_ILL: ;
            K_HALT: begin push_halt(); stop = 1; end
            K_R: begin
                push(0, 0, 0, S_EXEC_R, 0, 1, t_alu[idx], PC_ALU);
                push(0, 0, 0, S_WB, C_REGWR | C_RDST, 0, 0, PC_ALU);
            end
            K_I: begin
                push(0, 0, 0, S_EXEC_I, 0, 1, t_alu[idx], PC_ALU);
                push(0, 0, 0, S_WB, C_REGWR, 0, 0, PC_ALU);
            end
            K_LW, K_LL, K_SW, K_SC: begin
                md = (k == K_LW || k == K_LL) ? C_DREN : C_DWEN;
                push(0, 0, 0, S_EXEC_MEM, 0, 1, ALU_ADD, PC_ALU);
                for (int w = 0; w < dw; w++) begin
                    push(0, 0, 0, S_MEM, md, 0, 0, PC_ALU);
                    if (w == TMO) begin
                        m_tmo = 1; push_halt(); stop = 1; return;
                    end
                end
                push(0, 1, 0, S_MEM, md, 0, 0, PC_ALU);
                if (k == K_LW) push(0, 0, 0, S_WB, C_REGWR | C_M2R, 0, 0, PC_ALU);
                if (k == K_LL) push(0, 0, 0, S_WB, C_REGWR | C_M2R | C_LINK, 0, 0, PC_ALU);
                if (k == K_SC) push(0, 0, 0, S_WB, C_REGWR, 0, 0, PC_ALU);
            end
            K_BEQ, K_BNE:
                push(0, 0, z, S_BRANCH, ((z ^ (k == K_BNE)) != 0) ? C_PCWR : 12'h0,
                     1, ALU_SUB, PC_ALUOUT);
            K_J:   push(0, 0, 0, S_JUMP, C_PCWR, 0, 0, PC_JUMP);
            K_JAL: push(0, 0, 0, S_JUMP, C_PCWR | C_REGWR | C_LINK, 0, 0, PC_JUMP);
            K_JR:  push(0, 0, 0, S_JUMPR, C_PCWR, 0, 0, PC_JR);
            default: ;
        endcase
    endtask

    task automatic run(input int idx, input int limit);
        rec_t r;
        int   n = 0;
        while (q.size() > 0 && n < limit) begin
            r = q.pop_front();
            @(negedge CLK);
            nRST = 1'b1;
            if (n == 0) begin opcode = t_op[idx]; funct = t_fn[idx]; end
            ihit = r.ih; dhit = r.dh; zero = r.z;
            #1;
            chk("state", 32'(state_o), 32'(r.st));
            chk("ctl", 32'(ctl), 32'(r.c));
            if (r.ca) chk("aluop", 32'(ALUOp), 32'(r.alu));
            if ((r.c & C_PCWR) != 0) chk("pcsrc", 32'(PCSrc), 32'(r.pcs));
            chk("excl", 32'(dWEN & (RegWr | PCWr)), 32'd0);
            n++;
        end
        q.delete();
    endtask

    // Leaves nRST low; the next run() releases it on its first cycle.
    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; zero = 1'b0;
            #1;
            chk("rst_ctl", 32'(ctl), 32'(C_IREN));
            chk("rst_srcb", 32'(ALUSrcB), 32'(SRCB_FOUR));
            chk("rst_aluop", 32'(ALUOp), 32'(ALU_ADD));
            if (i > 0) chk("rst_state", 32'(state_o), 32'(S_FETCH));
        end
        m_tmo = 0;
    endtask

    task automatic instr(input int idx, input int fw, input int dw, input logic z);
        bit stop;
        q.delete();
        build(idx, fw, dw, z, stop);
        run(idx, 100000);
        if (stop) do_reset();
    endtask

    initial begin
        int idx, fw, dw;
        m_tmo = 0;
        do_reset();
        instr(0, 3, 0, 0);            // ADDU with 3 fetch waits: 7 cycles
        instr(13, 0, 2, 0);           // SW, dWEN held 3 cycles
        instr(17, 0, 0, 1);           // BNE zero=1: no PC write
        instr(17, 0, 0, 0);           // BNE zero=0: PC <- ALUOut
        instr(16, 1, 0, 1);           // BEQ taken
        instr(12, 1, 1, 0);           // LW
        instr(14, 0, 3, 0);           // LL
        instr(15, 0, 0, 0);           // SC
        instr(19, 0, 0, 0);           // JAL
        instr(7, 0, 0, 0);            // JR
        instr(11, 0, 0, 0);           // LUI
        instr(21, 0, 0, 0);           // illegal opcode
        instr(22, 0, 0, 0);           // illegal funct
        instr(0, TMO, 0, 0);          // hit on the limit cycle: no timeout
        instr(13, 0, TMO, 0);         // same at MEM
        instr(0, 50, 0, 0);           // ihit never: timeout then halt
        instr(12, 0, 50, 0);          // dhit never: timeout then halt
        instr(20, 0, 0, 0);           // HALT opcode
        // Reset during LW MEM wait: FETCH with dREN low afterwards
        q.delete();
        begin
            bit stop;
            build(12, 0, 3, 0, stop);
        end
        run(12, 4);
        do_reset();
        instr(8, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 23);
            if (idx == 20 && $urandom_range(0, 3) != 0) idx = 0;
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            instr(idx, fw, dw, 1'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
